// File: rtl/ttl_decade_chain_ctrl.sv
// Load/run/pause controller for a cascade of SN74LS160A-style BCD decade counters.
// Drives the chain's MR/PE/CEP/CET/P pins and watches its Q outputs for target match and wrap.
module ttl_decade_chain_ctrl #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  MR_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clr,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic [4*DIGITS-1:0]   target,
    input  logic [4*DIGITS-1:0]   chain_Q,
    output logic                  chain_MR_n,
    output logic                  chain_PE_n,
    output logic                  chain_CEP,
    output logic                  chain_CET,
    output logic [4*DIGITS-1:0]   chain_P,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  ovf,
    output logic                  err
);
    localparam int W = 4 * DIGITS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] preset_q, preset_d;
    logic [W-1:0] target_q, target_d;
    logic         ovf_q, ovf_d;
    logic         clr_pend_q;
    logic         match;
    logic         wrap;
    logic         load_ok;

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] v);
        logic nines;
        nines = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] != 4'd9) nines = 1'b0;
        end
        return nines;
    endfunction

    always_comb begin
        match      = (chain_Q == target_q);
        load_ok    = bcd_valid(preset) && bcd_valid(target);
        chain_CET  = (state_q == S_RUN);
        chain_CEP  = chain_CET && tick && !match;
        chain_PE_n = (state_q != S_LOAD);
        // The chain rolls over to all zeros when every stage sits at 9 and is enabled.
        wrap       = chain_CEP && chain_CET && all_nines(chain_Q);

        state_d  = state_q;
        preset_d = preset_q;
        target_d = target_q;
        ovf_d    = ovf_q;

        if (clr) begin
            state_d = S_IDLE;
            ovf_d   = 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                ovf_d = 1'b0;
            end else if (wrap) begin
                ovf_d = 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        preset_d = preset;
                        target_d = target;
                        state_d  = load_ok ? S_LOAD : S_ERR;
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (match) begin
                        state_d = S_DONE;
                    end else if (stop) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start) state_d = S_RUN;
                end
                default: begin
                    // ERR is only left through clr; unused encodings recover to IDLE.
                    if (state_q != S_ERR) state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            state_q    <= S_IDLE;
            preset_q   <= '0;
            target_q   <= '0;
            ovf_q      <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            target_q   <= target_d;
            ovf_q      <= ovf_d;
            clr_pend_q <= clr;
        end
    end

    // Chain clear follows a clr for one cycle, and tracks the board reset directly.
    assign chain_MR_n = MR_n && !clr_pend_q;
    assign chain_P    = preset_q;
    assign state      = state_q;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_ttl_decade_chain_ctrl.sv
// Bench for ttl_decade_chain_ctrl driving a 3-digit behavioural decade counter chain.
module tb_ttl_decade_chain_ctrl;
    localparam int D = 3;

    logic          clk = 1'b0;
    logic          MR_n;
    logic          start, stop, clr, tick;
    logic [11:0]   preset, target;
    logic [11:0]   chain_Q;
    logic          chain_MR_n, chain_PE_n, chain_CEP, chain_CET;
    logic [11:0]   chain_P;
    logic [2:0]    state;
    logic          done, ovf, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ttl_decade_chain_ctrl #(.DIGITS(D)) dut (
        .clk(clk), .MR_n(MR_n), .start(start), .stop(stop), .clr(clr), .tick(tick),
        .preset(preset), .target(target), .chain_Q(chain_Q),
        .chain_MR_n(chain_MR_n), .chain_PE_n(chain_PE_n), .chain_CEP(chain_CEP),
        .chain_CET(chain_CET), .chain_P(chain_P), .state(state),
        .done(done), .ovf(ovf), .err(err)
    );

    function automatic int from_bcd(input logic [11:0] v);
        int r = 0;
        int w = 1;
        for (int k = 0; k < D; k++) begin
            r = r + int'(v[4*k +: 4]) * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] b;
        int m = n;
        for (int k = 0; k < D; k++) begin
            b[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return b;
    endfunction

    function automatic bit bcd_ok(input logic [11:0] v);
        for (int k = 0; k < D; k++) begin
            if (((int'(v) >> (4*k)) % 16) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Counter chain as a plain decimal value 0..999.
    int cnt = 0;
    always @(posedge clk or negedge chain_MR_n) begin
        if (!chain_MR_n)                 cnt <= 0;
        else if (!chain_PE_n)            cnt <= from_bcd(chain_P);
        else if (chain_CEP && chain_CET) cnt <= (cnt + 1) % 1000;
    end
    assign chain_Q = to_bcd(cnt);

    // Reference model: states numbered IDLE=0 LOAD=1 RUN=2 PAUSE=3 DONE=4 ERR=5.
    int          m_st, m_cnt;
    logic [11:0] m_pre, m_tgt;
    bit          m_ovf, m_clrp;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_pre = '0; m_tgt = '0; m_ovf = 1'b0; m_clrp = 1'b0;
    endtask

    task automatic model_step();
        bit cep;
        int ncnt;
        int nst;
        cep  = (m_st == 2) && tick && (to_bcd(m_cnt) != m_tgt);
        ncnt = m_cnt;
        nst  = m_st;
        if (m_st == 1)  ncnt = from_bcd(m_pre);
        else if (cep)   ncnt = (m_cnt + 1) % 1000;
        if (clr || m_clrp) ncnt = 0;
        if (clr || m_st == 1)         m_ovf = 1'b0;
        else if (cep && m_cnt == 999) m_ovf = 1'b1;
        if (clr) nst = 0;
        else if ((m_st == 0 || m_st == 4) && start) begin
            m_pre = preset;
            m_tgt = target;
            nst   = (bcd_ok(preset) && bcd_ok(target)) ? 1 : 5;
        end
        else if (m_st == 1) nst = 2;
        else if (m_st == 2) nst = (to_bcd(m_cnt) == m_tgt) ? 4 : (stop ? 3 : 2);
        else if (m_st == 3 && start) nst = 2;
        m_clrp = clr;
        m_cnt  = ncnt;
        m_st   = nst;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit e_cep;
        e_cep = (m_st == 2) && tick && (to_bcd(m_cnt) != m_tgt);
        chk("state", int'(state), m_st);
        chk("done", int'(done), int'(m_st == 4));
        chk("err", int'(err), int'(m_st == 5));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("chain_CEP", int'(chain_CEP), int'(e_cep));
        chk("chain_CET", int'(chain_CET), int'(m_st == 2));
        chk("chain_PE_n", int'(chain_PE_n), int'(m_st != 1));
        chk("chain_MR_n", int'(chain_MR_n), int'(!m_clrp));
        chk("chain_P", int'(chain_P), int'(m_pre));
        chk("chain_Q", int'(chain_Q), int'(to_bcd(m_cnt)));
    endtask

    task automatic edge_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_model();
        edge_step();
    endtask

    typedef struct {
        bit st, sp, cl, tk;
        logic [11:0] pre, tgt;
        int          e_state;
        logic [11:0] e_q;
        bit e_done, e_ovf, e_err, e_cep, e_pe_n, e_mr_n;
    } vec_t;

    function automatic vec_t mk(input bit st, sp, cl, tk, input logic [11:0] pre, tgt,
                                input int es, input logic [11:0] eq,
                                input bit ed, eo, ee, ec, ep, em);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.tk = tk; v.pre = pre; v.tgt = tgt;
        v.e_state = es; v.e_q = eq; v.e_done = ed; v.e_ovf = eo; v.e_err = ee;
        v.e_cep = ec; v.e_pe_n = ep; v.e_mr_n = em;
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, summary %0d/%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        int idx;

        //            st sp cl tk pre      tgt       state q       dn ov er cep pe mr
        vecs[0]  = mk(1, 0, 0, 1, 12'h120, 12'h125, 0, 12'h000, 0, 0, 0, 0, 1, 1);
        vecs[1]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 1, 12'h000, 0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 2, 12'h120, 0, 0, 0, 1, 1, 1);
        vecs[3]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 2, 12'h121, 0, 0, 0, 1, 1, 1);
        vecs[4]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 2, 12'h122, 0, 0, 0, 1, 1, 1);
        vecs[5]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 2, 12'h123, 0, 0, 0, 1, 1, 1);
        vecs[6]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 2, 12'h124, 0, 0, 0, 1, 1, 1);
        vecs[7]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 2, 12'h125, 0, 0, 0, 0, 1, 1);
        vecs[8]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 4, 12'h125, 1, 0, 0, 0, 1, 1);
        vecs[9]  = mk(0, 0, 0, 1, 12'h120, 12'h125, 4, 12'h125, 1, 0, 0, 0, 1, 1);
        vecs[10] = mk(0, 0, 1, 1, 12'h120, 12'h125, 4, 12'h125, 1, 0, 0, 0, 1, 1);
        vecs[11] = mk(0, 0, 0, 1, 12'h120, 12'h125, 0, 12'h000, 0, 0, 0, 0, 1, 0);
        vecs[12] = mk(1, 0, 0, 1, 12'h0A0, 12'h125, 0, 12'h000, 0, 0, 0, 0, 1, 1);
        vecs[13] = mk(0, 0, 0, 1, 12'h0A0, 12'h125, 5, 12'h000, 0, 0, 1, 0, 1, 1);
        vecs[14] = mk(1, 0, 0, 1, 12'h0A0, 12'h125, 5, 12'h000, 0, 0, 1, 0, 1, 1);
        vecs[15] = mk(0, 0, 0, 1, 12'h0A0, 12'h125, 5, 12'h000, 0, 0, 1, 0, 1, 1);
        vecs[16] = mk(0, 0, 1, 1, 12'h0A0, 12'h125, 5, 12'h000, 0, 0, 1, 0, 1, 1);
        vecs[17] = mk(0, 0, 0, 1, 12'h0A0, 12'h125, 0, 12'h000, 0, 0, 0, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 1, 12'h0A0, 12'h125, 0, 12'h000, 0, 0, 0, 0, 1, 1);

        MR_n = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; tick = 1'b0;
        preset = '0; target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_flags", int'({done, ovf, err}), 0);
        chk("rst_pe_n", int'(chain_PE_n), 1);
        chk("rst_cep_cet", int'({chain_CEP, chain_CET}), 0);
        chk("rst_P", int'(chain_P), 0);
        chk("rst_chain_mr_n", int'(chain_MR_n), 0);
        @(negedge clk);
        MR_n = 1'b1;
        edge_step();

        // Table: load-and-run to target, then bad BCD preset into ERR.
        for (int i = 0; i < 19; i++) begin
            start = vecs[i].st; stop = vecs[i].sp; clr = vecs[i].cl; tick = vecs[i].tk;
            preset = vecs[i].pre; target = vecs[i].tgt;
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].e_state);
            chk($sformatf("vec%0d_Q", i), int'(chain_Q), int'(vecs[i].e_q));
            chk($sformatf("vec%0d_flags", i), int'({done, ovf, err}),
                int'({vecs[i].e_done, vecs[i].e_ovf, vecs[i].e_err}));
            chk($sformatf("vec%0d_cep", i), int'(chain_CEP), int'(vecs[i].e_cep));
            chk($sformatf("vec%0d_pe_n", i), int'(chain_PE_n), int'(vecs[i].e_pe_n));
            chk($sformatf("vec%0d_mr_n", i), int'(chain_MR_n), int'(vecs[i].e_mr_n));
            edge_step();
        end
        start = 1'b0; clr = 1'b0;

        // Wrap through 999 -> 000 on the way to 002.
        preset = 12'h998; target = 12'h002; start = 1'b1; tick = 1'b1;
        run_cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && state != 3'd4; i++) run_cycle();
        chk("wrap_state", int'(state), 4);
        chk("wrap_ovf", int'(ovf), 1);
        chk("wrap_Q", int'(chain_Q), 'h002);
        chk("wrap_done", int'(done), 1);
        run_cycle();
        chk("wrap_done_cep", int'(chain_CEP), 0);

        // Preset equals target: reload from DONE, finish after one RUN cycle.
        preset = 12'h050; target = 12'h050; start = 1'b1;
        run_cycle();
        start = 1'b0;
        run_cycle();
        chk("eq_run_state", int'(state), 2);
        chk("eq_run_cep", int'(chain_CEP), 0);
        chk("eq_ovf_cleared", int'(ovf), 0);
        run_cycle();
        chk("eq_done_state", int'(state), 4);
        chk("eq_done_Q", int'(chain_Q), 'h050);

        // Pause at 010, ticks ignored, resume from 010.
        preset = 12'h005; target = 12'h020; start = 1'b1;
        run_cycle();
        start = 1'b0;
        for (int i = 0; i < 30 && chain_Q != 12'h010; i++) run_cycle();
        chk("pause_reach_Q", int'(chain_Q), 'h010);
        tick = 1'b0; stop = 1'b1;
        run_cycle();
        stop = 1'b0; tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            chk($sformatf("pause%0d_state", i), int'(state), 3);
            chk($sformatf("pause%0d_Q", i), int'(chain_Q), 'h010);
        end
        tick = 1'b0; start = 1'b1;
        run_cycle();
        start = 1'b0; tick = 1'b1;
        run_cycle();
        chk("resume_Q", int'(chain_Q), 'h011);

        // Asynchronous reset mid-RUN, then clr beating start.
        chk("mr_pre_state", int'(state), 2);
        #2 MR_n = 1'b0;
        #1;
        chk("mr_state", int'(state), 0);
        chk("mr_Q", int'(chain_Q), 0);
        chk("mr_flags", int'({done, ovf, err}), 0);
        chk("mr_pe_n", int'(chain_PE_n), 1);
        chk("mr_cep_cet", int'({chain_CEP, chain_CET}), 0);
        chk("mr_P", int'(chain_P), 0);
        chk("mr_chain_mr_n", int'(chain_MR_n), 0);
        @(negedge clk);
        MR_n = 1'b1;
        model_reset();
        edge_step();
        for (int i = 0; i < 3; i++) run_cycle();
        clr = 1'b1; start = 1'b1; preset = 12'h100; target = 12'h105;
        run_cycle();
        chk("clr_wins_state", int'(state), 0);
        chk("clr_wins_mr_n", int'(chain_MR_n), 0);
        clr = 1'b0; start = 1'b0;
        run_cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            clr   = ($urandom_range(0, 59) == 0);
            tick  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(985, 999))
                                                : int'($urandom_range(0, 999));
                preset = to_bcd(p);
                target = to_bcd((p + int'($urandom_range(0, 25))) % 1000);
                if ($urandom_range(0, 9) == 0) begin
                    idx = int'($urandom_range(0, 2));
                    preset[4*idx +: 4] = 4'($urandom_range(10, 15));
                end
            end
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
